// File: rtl/display_scan.sv
// Four-digit multiplexed 7-segment driver for an MM:SS stopwatch display.
// Digits are refreshed one at a time from a per-frame snapshot, with optional field blinking.
module display_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       timer,
    input  logic       reset,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic [1:0] blink_sel,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX   = BW'(BLINK_DIV - 1);

    logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic [1:0]    digit_idx_q, digit_idx_d;
    logic          blink_phase_q, blink_phase_d;
    logic [5:0]    min_sh_q, min_sh_d;
    logic [5:0]    sec_sh_q, sec_sh_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          dp_q, dp_d;

    logic          digit_tick;
    logic          blink_wrap;
    logic          blank;
    logic [3:0]    digit;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Scan timing and per-frame snapshot
    always_comb begin
        digit_tick    = (refresh_cnt_q == REFRESH_MAX);
        refresh_cnt_d = digit_tick ? '0 : refresh_cnt_q + RW'(1);
        digit_idx_d   = digit_tick ? digit_idx_q + 2'd1 : digit_idx_q;
        // Snapshot is taken on the tick that starts a new frame at idx0.
        min_sh_d      = (digit_tick && digit_idx_q == 2'd3) ? minutes : min_sh_q;
        sec_sh_d      = (digit_tick && digit_idx_q == 2'd3) ? seconds : sec_sh_q;
        blink_wrap    = (blink_cnt_q == BLINK_MAX);
        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q ^ blink_wrap;
    end

    // Output decode, registered one cycle later
    always_comb begin
        case (digit_idx_q)
            2'd0:    digit = 4'(sec_sh_q % 6'd10);
            2'd1:    digit = 4'(sec_sh_q / 6'd10);
            2'd2:    digit = 4'(min_sh_q % 6'd10);
            default: digit = 4'(min_sh_q / 6'd10);
        endcase
        blank = blink_phase_q && (digit_idx_q[1] ? blink_sel[0] : blink_sel[1]);
        an_d  = blank ? 4'b1111 : ~(4'b0001 << digit_idx_q);
        seg_d = blank ? 7'b1111111 : seg7(digit);
        dp_d  = blank || (digit_idx_q != 2'd2);
    end

    always_ff @(posedge timer or negedge reset) begin
        if (!reset) begin
            refresh_cnt_q <= '0;
            blink_cnt_q   <= '0;
            digit_idx_q   <= 2'd0;
            blink_phase_q <= 1'b0;
            min_sh_q      <= 6'd0;
            sec_sh_q      <= 6'd0;
            seg_q         <= 7'b1111111;
            an_q          <= 4'b1111;
            dp_q          <= 1'b1;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            digit_idx_q   <= digit_idx_d;
            blink_phase_q <= blink_phase_d;
            min_sh_q      <= min_sh_d;
            sec_sh_q      <= sec_sh_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            dp_q          <= dp_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with REFRESH_DIV=4, BLINK_DIV=8.
// Expected digits per frame and segment codes are hand-written tables.
module tb_display_scan;

    logic       timer = 1'b0;
    logic       reset;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] blink_sel;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int n_tests = 0;
    int n_fail  = 0;
    int k;
    int fd [0:8][0:3];
    logic [6:0] segtab [0:9];

    always #5 timer = ~timer;

    display_scan #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
        .timer     (timer),
        .reset     (reset),
        .minutes   (minutes),
        .seconds   (seconds),
        .blink_sel (blink_sel),
        .seg       (seg),
        .an        (an),
        .dp        (dp)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, " an"},  32'(an),  32'(4'b1111));
        check_val({tag, " seg"}, 32'(seg), 32'(7'b1111111));
        check_val({tag, " dp"},  32'(dp),  32'(1'b1));
    endtask

    // One edge: frame f, digit idx, blink phase derived from edges since reset release.
    task automatic step_check();
        logic [1:0] sel;
        logic [3:0] one;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       blank;
        int f, idx, ph;
        sel = blink_sel;
        @(posedge timer);
        @(negedge timer);
        k++;
        f   = (k - 1) / 16;
        idx = ((k - 1) / 4) % 4;
        ph  = ((k - 1) / 8) % 2;
        blank = (ph == 1) && ((idx >= 2 && sel[0]) || (idx < 2 && sel[1]));
        one   = 4'b0001;
        e_an  = blank ? 4'b1111 : ~(one << idx);
        e_seg = blank ? 7'b1111111 : segtab[fd[f][idx]];
        e_dp  = blank ? 1'b1 : (idx != 2);
        check_val($sformatf("k%0d an", k),  32'(an),  32'(e_an));
        check_val($sformatf("k%0d seg", k), 32'(seg), 32'(e_seg));
        check_val($sformatf("k%0d dp", k),  32'(dp),  32'(e_dp));
    endtask

    initial begin
        segtab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                   7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        fd[0] = '{0, 0, 0, 0};
        fd[1] = '{4, 3, 2, 1};
        fd[2] = '{5, 3, 2, 1};
        for (int i = 3; i <= 8; i++) fd[i] = '{9, 5, 3, 6};

        reset     = 1'b0;
        minutes   = 6'd12;
        seconds   = 6'd34;
        blink_sel = 2'b00;
        #12;
        check_reset_state("por");

        @(negedge timer);
        reset = 1'b1;
        k = 0;
        for (int i = 0; i < 134; i++) begin
            if (k == 22) seconds = 6'd35;
            if (k == 40) begin
                minutes = 6'd63;
                seconds = 6'd59;
            end
            if (k == 64)  blink_sel = 2'b01;
            if (k == 80)  blink_sel = 2'b10;
            if (k == 96)  blink_sel = 2'b11;
            if (k == 112) blink_sel = 2'b00;
            if (k == 120) blink_sel = 2'b01;
            step_check();
        end

        blink_sel = 2'b00;
        #2;
        reset = 1'b0;
        #1;
        check_reset_state("midrst");
        @(negedge timer);
        check_reset_state("held");
        @(negedge timer);
        reset = 1'b1;
        k = 0;
        fd[0] = '{0, 0, 0, 0};
        fd[1] = '{9, 5, 3, 6};
        for (int i = 0; i < 32; i++) step_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles each digit stays lit (legal range 2 to 2^20).
REQ-002 Parameter BLINK_DIV, default 25000000, clock cycles per blink half-period (legal range 2 to 2^27).
REQ-003 Port timer  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port minutes  input  6  binary minutes value from the stopwatch counter (0-63 accepted).
REQ-006 Port seconds  input  6  binary seconds value from the stopwatch counter (0-63 accepted).
REQ-007 Port blink_sel  input  2  00 no blink, 01 blink minutes digits, 10 blink seconds digits, 11 blink all four digits.
REQ-008 Port seg  output  7  active-low segments {g,f,e,d,c,b,a}, registered.
REQ-009 Port an  output  4  active-low digit anodes, one-hot-low, registered.
REQ-010 Port dp  output  1  active-low decimal point, registered.

Function
REQ-011 refresh_cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; the wrap cycle is the "digit tick".
REQ-012 On each digit tick, digit_idx (2 bits) SHALL advance modulo 4 (3 -> 0).
REQ-013 Digit mapping SHALL be: idx0 seconds ones on an[0], idx1 seconds tens on an[1], idx2 minutes ones on an[2], idx3 minutes tens on an[3].
REQ-014 Shadow registers min_sh/sec_sh SHALL load minutes/seconds only on the digit tick where digit_idx == 3, so each frame displays one coherent snapshot.
REQ-015 Inputs changing at any other time SHALL NOT affect the display until the next frame boundary.
REQ-016 Each field SHALL be split into tens = value/10 and ones = value mod 10; 60-63 display as tens 6, ones 0-3.
REQ-017 Segment codes SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-018 seg, an, dp SHALL be registered every cycle from current digit_idx, shadows, and blink state (one-cycle latency).
REQ-019 dp SHALL be 0 while idx2 is displayed (colon between minutes and seconds), else 1.
REQ-020 blink_cnt SHALL count 0..BLINK_DIV-1 and toggle blink_phase on wrap; it runs regardless of blink_sel.
REQ-021 When blink_phase == 1 and blink_sel selects the current digit's field, an SHALL be 1111 and dp 1 for that cycle; seg is don't-care but SHALL be 1111111.
REQ-022 blink_sel is sampled combinationally into the output register each cycle; changes take effect with one-cycle latency.

Reset
REQ-023 While reset == 0: refresh_cnt, blink_cnt, digit_idx, blink_phase, min_sh, sec_sh SHALL be 0; an = 1111, seg = 1111111, dp = 1, immediately and independent of timer.
REQ-024 Reset asserted mid-frame SHALL abort the frame; after release, the first displayed digit is idx0 showing 0 until the first shadow load.

Verification (REFRESH_DIV=4, BLINK_DIV=8)
REQ-025 Reset: pull reset low mid-scan -> an=1111, seg=1111111, dp=1 without a clock edge; release -> an=1110, seg=1000000 one cycle later.
REQ-026 Scan: minutes=12, seconds=34 held past first frame -> sequence an=1110/seg=0011001, 1101/0110000, 1011/0100100 with dp=0, 0111/1111001, 4 cycles each.
REQ-027 Coherency: change seconds 34->35 while idx1 is lit -> idx0 still shows 4 in current frame; 5 from next frame.
REQ-028 Range: minutes=63, seconds=59 -> minutes tens 0000010 (6), ones 0110000 (3); seconds tens 0010010, ones 0010000.
REQ-029 Blink: blink_sel=01 -> an[3:2] digits blanked (an=1111, dp=1) for 8 cycles, lit 8 cycles, repeating; seconds digits unaffected.
REQ-030 Wrap: digit tick at idx3 -> digit_idx=0 and shadows load in the same edge; new values appear on an[0] next cycle.
